instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch sequencer of the von Neumann CPU, sitting directly downstream of the PC. It reads the PC value, issues the read on the shared memory bus, latches the returned word into the instruction register, and hands it to the execute stage over a valid/ready handshake. It also generates the PC increment and jump-load pulses.

## Interface
- ADDR_W, 12, address width; matches PC width
- DATA_W, 16, memory word / instruction width
- OPC_W, 4, opcode field width; IR[DATA_W-1 -: OPC_W]
- clk  in  1  system clock; all state changes on the rising edge
- REST_N  in  1  reset, asynchronous, active-low
- START  in  1  level; leave IDLE and begin fetching
- HALT  in  1  level; return to IDLE at the next safe point
- PC_Q  in  ADDR_W  current PC value (PC DATA_OUT)
- PC_EN  out  1  one-cycle PC increment pulse
- PC_LOAD  out  1  one-cycle PC load pulse
- PC_DIN  out  ADDR_W  PC load value
- MEM_RD  out  1  read request, held until acknowledged
- MEM_ADDR  out  ADDR_W  read address, stable while MEM_RD=1
- MEM_ACK  in  1  read done; meaningful only while MEM_RD=1
- MEM_RDATA  in  DATA_W  read data, valid with MEM_ACK
- BUS_BUSY  in  1  execute stage owns the bus; no new read is issued
- IR  out  DATA_W  instruction register
- OPCODE  out  OPC_W  IR upper field
- OPERAND  out  DATA_W-OPC_W  IR lower field
- INSTR_PC  out  ADDR_W  address the IR was fetched from
- IR_VALID  out  1  IR holds an unconsumed instruction
- IR_READY  in  1  execute stage accepts the IR
- JMP_EN  in  1  redirect fetch to JMP_ADDR
- JMP_ADDR  in  ADDR_W  jump target

## Operation
- States: IDLE, REQ, WAIT, HOLD, JUMP, DRAIN. All outputs are registered.
- IDLE: START=1 -> REQ. JMP_EN=1 -> PC_LOAD pulse, PC_DIN=JMP_ADDR, stay in IDLE (boot vector).
- REQ: HALT=1 -> IDLE. Otherwise, if BUS_BUSY=0: MEM_RD<=1, MEM_ADDR<=PC_Q, go to WAIT. If BUS_BUSY=1, stay in REQ.
- WAIT: on MEM_ACK=1: IR<=MEM_RDATA, INSTR_PC<=MEM_ADDR, MEM_RD<=0, IR_VALID<=1, PC_EN pulse, go to HOLD.
- HOLD: IR is stable. On IR_READY=1: IR_VALID<=0, then HALT ? IDLE : REQ.
- JMP_EN in REQ/HOLD: PC_LOAD pulse, PC_DIN<=JMP_ADDR, IR_VALID<=0, go to JUMP. It overrides the handshake and HALT.
- JMP_EN in WAIT: PC_LOAD pulse, go to DRAIN. If MEM_ACK arrives in the same cycle: data discarded, no PC_EN, MEM_RD<=0, go to JUMP.
- DRAIN: wait for MEM_ACK, discard the data, no PC_EN, MEM_RD<=0, go to JUMP.
- JUMP: one cycle so the PC absorbs the load; then HALT ? IDLE : REQ.
- JMP_EN in JUMP/DRAIN is ignored. HALT is ignored outside REQ, HOLD and JUMP.
- Invariants: PC_EN and PC_LOAD are never high in the same cycle. MEM_ADDR never changes while MEM_RD=1. IR never changes while IR_VALID=1.

## Timing
- Reset: state IDLE; every output 0 (IR, INSTR_PC, MEM_ADDR, PC_DIN all zero).
- Fetch latency, with bus free and zero-wait memory (MEM_ACK in the first WAIT cycle): REQ edge -> MEM_RD high; ack edge -> IR_VALID high next cycle.
- Back-to-back throughput with IR_READY held high and zero-wait memory: one instruction per 3 cycles (REQ, WAIT, HOLD).
- PC_EN is high in the cycle after the ack edge, so the PC updates before the next REQ samples PC_Q.
- Jump: PC_LOAD is high in the cycle after JMP_EN is sampled. The first read of the target is issued 2 edges later with the bus free.
- REST_N asserted mid-transaction: immediate IDLE. MEM_RD drops asynchronously; the outstanding read is abandoned.

## Structure
- Shared package vn_pkg holds ADDR_W, DATA_W, OPC_W, the fetch-state enum, and the opcode field slice positions, so decode and execute use the same definitions.
- Single module; no sub-module. IR and field split stay inline.

## Test plan
- Reset, then PC_Q=0x006, START=1, zero-wait ack with RDATA=0x1ABC -> MEM_ADDR=0x006, IR=0x1ABC, OPCODE=0x1, OPERAND=0xABC, INSTR_PC=0x006, one PC_EN pulse.
- IR_READY held low 5 cycles after a fetch -> IR_VALID stays 1, IR unchanged, MEM_RD stays 0; IR_READY=1 -> next read at the incremented PC_Q.
- BUS_BUSY=1 for 4 cycles in REQ -> MEM_RD stays 0; BUS_BUSY=0 -> read issued the next edge.
- JMP_EN=1 with JMP_ADDR=0x0F0 coinciding with MEM_ACK in WAIT -> data discarded, no PC_EN, PC_LOAD pulse with PC_DIN=0x0F0, next MEM_ADDR=0x0F0.
- JMP_EN in WAIT with the ack 3 cycles late -> DRAIN, IR unchanged and IR_VALID=0, one PC_LOAD, zero PC_EN.
- REST_N low while MEM_RD=1 -> MEM_RD=0 and IR_VALID=0 immediately; HALT in HOLD with IR_READY=1 -> IDLE, no further MEM_RD.

Source files
------------

// File: rtl/vn_pkg.sv
// Shared definitions for the fetch sequencer, the decoder and the execute stage.
// Address width, word width, opcode field position and the fetch-state encoding.
// One source of truth so that every stage slices the instruction the same way.
package vn_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int OPC_W   = 4;

    // The opcode occupies the top OPC_W bits of the word; the operand is the rest.
    localparam int OPC_MSB = DATA_W - 1;
    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int OPND_W  = DATA_W - OPC_W;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_JUMP,
        FS_DRAIN
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OPND_W-1:0] operand_of(input logic [DATA_W-1:0] word);
        return word[OPND_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads at PC_Q, latches the word into IR, presents it to execute.
// Latency: read issued one edge after REQ; IR_VALID high one edge after MEM_ACK (3 cycles/instr).
// Backpressure: IR_READY low holds IR and stalls further reads; BUS_BUSY holds off new reads.
// Ports: clk/REST_N; START/HALT control; PC_Q in, PC_EN/PC_LOAD/PC_DIN to the PC;
//        MEM_RD/MEM_ADDR/MEM_ACK/MEM_RDATA/BUS_BUSY memory bus; IR/OPCODE/OPERAND/INSTR_PC/
//        IR_VALID/IR_READY to execute; JMP_EN/JMP_ADDR redirect from execute.
module instr_fetch
    import vn_pkg::*;
(
    input  logic              clk,
    input  logic              REST_N,
    input  logic              START,
    input  logic              HALT,
    input  logic [ADDR_W-1:0] PC_Q,
    output logic              PC_EN,
    output logic              PC_LOAD,
    output logic [ADDR_W-1:0] PC_DIN,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              BUS_BUSY,
    output logic [DATA_W-1:0] IR,
    output logic [OPC_W-1:0]  OPCODE,
    output logic [OPND_W-1:0] OPERAND,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic              IR_VALID,
    input  logic              IR_READY,
    input  logic              JMP_EN,
    input  logic [ADDR_W-1:0] JMP_ADDR
);

    fetch_state_t state;

    // Field split is a pure slice of the IR register, so it is as stable as IR itself.
    assign OPCODE  = opcode_of(IR);
    assign OPERAND = operand_of(IR);

    always_ff @(posedge clk or negedge REST_N) begin
        if (!REST_N) begin
            state    <= FS_IDLE;
            PC_EN    <= 1'b0;
            PC_LOAD  <= 1'b0;
            PC_DIN   <= '0;
            MEM_RD   <= 1'b0;
            MEM_ADDR <= '0;
            IR       <= '0;
            INSTR_PC <= '0;
            IR_VALID <= 1'b0;
        end else begin
            // PC control outputs are single-cycle pulses.
            PC_EN   <= 1'b0;
            PC_LOAD <= 1'b0;

            case (state)
                FS_IDLE: begin
                    // A jump while idle only sets the boot vector; fetching waits for START.
                    if (JMP_EN) begin
                        PC_LOAD <= 1'b1;
                        PC_DIN  <= JMP_ADDR;
                    end else if (START) begin
                        state <= FS_REQ;
                    end
                end

                FS_REQ: begin
                    if (JMP_EN) begin
                        PC_LOAD  <= 1'b1;
                        PC_DIN   <= JMP_ADDR;
                        IR_VALID <= 1'b0;
                        state    <= FS_JUMP;
                    end else if (HALT) begin
                        state <= FS_IDLE;
                    end else if (!BUS_BUSY) begin
                        MEM_RD   <= 1'b1;
                        MEM_ADDR <= PC_Q;
                        state    <= FS_WAIT;
                    end
                end

                FS_WAIT: begin
                    if (JMP_EN) begin
                        // The in-flight read is now stale: its data is dropped and the
                        // PC is not incremented, since the load supersedes it.
                        PC_LOAD <= 1'b1;
                        PC_DIN  <= JMP_ADDR;
                        if (MEM_ACK) begin
                            MEM_RD <= 1'b0;
                            state  <= FS_JUMP;
                        end else begin
                            state <= FS_DRAIN;
                        end
                    end else if (MEM_ACK) begin
                        IR       <= MEM_RDATA;
                        INSTR_PC <= MEM_ADDR;
                        MEM_RD   <= 1'b0;
                        IR_VALID <= 1'b1;
                        PC_EN    <= 1'b1;
                        state    <= FS_HOLD;
                    end
                end

                FS_HOLD: begin
                    if (JMP_EN) begin
                        PC_LOAD  <= 1'b1;
                        PC_DIN   <= JMP_ADDR;
                        IR_VALID <= 1'b0;
                        state    <= FS_JUMP;
                    end else if (IR_READY) begin
                        IR_VALID <= 1'b0;
                        state    <= HALT ? FS_IDLE : FS_REQ;
                    end
                end

                FS_DRAIN: begin
                    // The bus protocol requires the read to complete before a new one.
                    if (MEM_ACK) begin
                        MEM_RD <= 1'b0;
                        state  <= FS_JUMP;
                    end
                end

                FS_JUMP: begin
                    // One settling cycle so PC_Q shows the jump target before REQ samples it.
                    state <= HALT ? FS_IDLE : FS_REQ;
                end

                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import vn_pkg::*;

    logic              clk = 1'b0;
    logic              REST_N;
    logic              START, HALT, BUS_BUSY, MEM_ACK, IR_READY, JMP_EN;
    logic [DATA_W-1:0] MEM_RDATA;
    logic [ADDR_W-1:0] JMP_ADDR;
    logic [ADDR_W-1:0] PC_Q;
    logic              PC_EN, PC_LOAD, MEM_RD, IR_VALID;
    logic [ADDR_W-1:0] PC_DIN, MEM_ADDR, INSTR_PC;
    logic [DATA_W-1:0] IR;
    logic [OPC_W-1:0]  OPCODE;
    logic [OPND_W-1:0] OPERAND;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .REST_N(REST_N), .START(START), .HALT(HALT), .PC_Q(PC_Q),
        .PC_EN(PC_EN), .PC_LOAD(PC_LOAD), .PC_DIN(PC_DIN),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUS_BUSY(BUS_BUSY), .IR(IR), .OPCODE(OPCODE), .OPERAND(OPERAND),
        .INSTR_PC(INSTR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
        .JMP_EN(JMP_EN), .JMP_ADDR(JMP_ADDR)
    );

    // Program counter the sequencer drives: load wins, otherwise increment.
    logic [ADDR_W-1:0] pc;
    always @(posedge clk or negedge REST_N) begin
        if (!REST_N)      pc <= '0;
        else if (PC_LOAD) pc <= PC_DIN;
        else if (PC_EN)   pc <= pc + 1'b1;
    end
    assign PC_Q = pc;

    // Invariant monitor, sampled on the falling edge.
    int                inv_err = 0;
    logic              p_rd = 1'b0, p_v = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_ir = '0;
    always @(negedge clk) begin
        if (REST_N) begin
            if (PC_EN && PC_LOAD) inv_err++;
            if (p_rd && MEM_RD && MEM_ADDR != p_addr) inv_err++;
            if (p_v && IR_VALID && IR != p_ir) inv_err++;
        end
        p_rd = MEM_RD; p_addr = MEM_ADDR; p_v = IR_VALID; p_ir = IR;
    end

    typedef struct {
        logic st, hl, bb, ack;
        logic [15:0] rdata;
        logic rdy, jen;
        logic [11:0] jaddr;
        logic e_rd;
        logic [11:0] e_addr;
        logic e_v;
        logic [15:0] e_ir;
        logic [11:0] e_ipc;
        logic e_en, e_ld;
        logic [11:0] e_din;
    } vec_t;

    vec_t vecs[$];
    int applied = 0;
    int miscompares = 0;

    task automatic add(input logic st, hl, bb, ack, input logic [15:0] rdata,
                       input logic rdy, jen, input logic [11:0] jaddr,
                       input logic e_rd, input logic [11:0] e_addr, input logic e_v,
                       input logic [15:0] e_ir, input logic [11:0] e_ipc,
                       input logic e_en, e_ld, input logic [11:0] e_din);
        vec_t v;
        v.st = st; v.hl = hl; v.bb = bb; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.jen = jen; v.jaddr = jaddr; v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v;
        v.e_ir = e_ir; v.e_ipc = e_ipc; v.e_en = e_en; v.e_ld = e_ld; v.e_din = e_din;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        START = 0; HALT = 0; BUS_BUSY = 0; MEM_ACK = 0; MEM_RDATA = '0;
        IR_READY = 0; JMP_EN = 0; JMP_ADDR = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            START = vecs[i].st; HALT = vecs[i].hl; BUS_BUSY = vecs[i].bb;
            MEM_ACK = vecs[i].ack; MEM_RDATA = vecs[i].rdata; IR_READY = vecs[i].rdy;
            JMP_EN = vecs[i].jen; JMP_ADDR = vecs[i].jaddr;
            tick();
            applied++;
            if (MEM_RD !== vecs[i].e_rd || MEM_ADDR !== vecs[i].e_addr ||
                IR_VALID !== vecs[i].e_v || IR !== vecs[i].e_ir ||
                INSTR_PC !== vecs[i].e_ipc || PC_EN !== vecs[i].e_en ||
                PC_LOAD !== vecs[i].e_ld || PC_DIN !== vecs[i].e_din) begin
                miscompares++;
                $display("FAIL vec%0d: got rd=%b addr=%h v=%b ir=%h ipc=%h en=%b ld=%b din=%h, expected rd=%b addr=%h v=%b ir=%h ipc=%h en=%b ld=%b din=%h",
                         i, MEM_RD, MEM_ADDR, IR_VALID, IR, INSTR_PC, PC_EN, PC_LOAD, PC_DIN,
                         vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_ir,
                         vecs[i].e_ipc, vecs[i].e_en, vecs[i].e_ld, vecs[i].e_din);
            end
        end
        idle_inputs();
    endtask

    int rd_seen;

    initial begin
        //   st hl bb ack rdata     rdy jen jaddr   | rd addr    v ir        ipc     en ld din
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h000, 0, 16'h0000, 12'h000, 0, 0, 12'h000); // 0 reset state
        add(0, 0, 0, 0, 16'h0000, 0, 1, 12'h006,   0, 12'h000, 0, 16'h0000, 12'h000, 0, 1, 12'h006); // 1 boot vector
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h000, 0, 16'h0000, 12'h000, 0, 0, 12'h006); // 2
        add(1, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h000, 0, 16'h0000, 12'h000, 0, 0, 12'h006); // 3 -> REQ
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   1, 12'h006, 0, 16'h0000, 12'h000, 0, 0, 12'h006); // 4 read 006
        add(0, 0, 0, 1, 16'h1ABC, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 1, 0, 12'h006); // 5 ack
        // IR_READY low for 5 cycles; a stray ack in HOLD must not touch IR
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 6
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 7
        add(0, 0, 0, 1, 16'hFFFF, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 8
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 9
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 1, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 10
        add(0, 0, 0, 0, 16'h0000, 1, 0, 12'h000,   0, 12'h006, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 11 consumed
        // bus busy 4 cycles in REQ
        add(0, 0, 1, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 12
        add(0, 0, 1, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 13
        add(0, 0, 1, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 14
        add(0, 0, 1, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h006, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 15
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   1, 12'h007, 0, 16'h1ABC, 12'h006, 0, 0, 12'h006); // 16 read 007
        // jump coinciding with ack
        add(0, 0, 0, 1, 16'h2345, 0, 1, 12'h0F0,   0, 12'h007, 0, 16'h1ABC, 12'h006, 0, 1, 12'h0F0); // 17
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h007, 0, 16'h1ABC, 12'h006, 0, 0, 12'h0F0); // 18 JUMP
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   1, 12'h0F0, 0, 16'h1ABC, 12'h006, 0, 0, 12'h0F0); // 19 read 0F0
        add(0, 0, 0, 1, 16'h5F0F, 1, 0, 12'h000,   0, 12'h0F0, 1, 16'h5F0F, 12'h0F0, 1, 0, 12'h0F0); // 20
        add(0, 0, 0, 0, 16'h0000, 1, 0, 12'h000,   0, 12'h0F0, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h0F0); // 21
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   1, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h0F0); // 22 read 0F1
        // jump in WAIT, ack three cycles late; second jump in DRAIN ignored
        add(0, 0, 0, 0, 16'h0000, 0, 1, 12'h123,   1, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 1, 12'h123); // 23 DRAIN
        add(0, 0, 0, 0, 16'h0000, 0, 1, 12'h3FF,   1, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h123); // 24
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   1, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h123); // 25
        add(0, 0, 0, 1, 16'hDEAD, 0, 0, 12'h000,   0, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h123); // 26 JUMP
        add(0, 1, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h123); // 27 halt -> IDLE
        add(0, 0, 0, 0, 16'h0000, 0, 0, 12'h000,   0, 12'h0F1, 0, 16'h5F0F, 12'h0F0, 0, 0, 12'h123); // 28 idle

        idle_inputs();
        REST_N = 0;
        repeat (3) @(negedge clk);
        REST_N = 1;

        run_vectors(0, 5);
        check("opcode", 32'(OPCODE), 32'h1);
        check("operand", 32'(OPERAND), 32'hABC);
        run_vectors(6, vecs.size() - 1);
        check("pc_after_drain", 32'(pc), 32'h123);

        // Reset asserted while a read is outstanding
        START = 1; tick(); START = 0; tick();
        check("rd_before_reset", {19'd0, MEM_RD, MEM_ADDR}, {19'd0, 1'b1, 12'h123});
        #2 REST_N = 0;
        #1;
        check("rd_async_reset", 32'(MEM_RD), 32'h0);
        check("valid_async_reset", 32'(IR_VALID), 32'h0);
        check("ir_async_reset", 32'(IR), 32'h0);
        @(negedge clk);
        REST_N = 1;

        // HALT in HOLD with IR_READY -> IDLE, no further read
        START = 1; tick(); START = 0; tick();
        check("rd_after_restart", {19'd0, MEM_RD, MEM_ADDR}, {19'd0, 1'b1, 12'h000});
        MEM_ACK = 1; MEM_RDATA = 16'h7777; tick(); MEM_ACK = 0; MEM_RDATA = '0;
        check("hold_ir", {15'd0, IR_VALID, IR}, {15'd0, 1'b1, 16'h7777});
        HALT = 1; IR_READY = 1; tick(); HALT = 0; IR_READY = 0;
        check("halt_valid", 32'(IR_VALID), 32'h0);
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (MEM_RD) rd_seen++;
        end
        check("no_read_after_halt", 32'(rd_seen), 32'h0);
        check("pc_after_halt", 32'(pc), 32'h001);

        check("invariants", 32'(inv_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
